// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths, address shift and writeback state type
package systolic_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int BYTES_PER_WORD = 8;
  localparam int WORD_SHIFT = 3;
  typedef enum logic [1:0] {IDLE, WAIT_ROW, WRITE, DONE} wb_state_t;
endpackage

// File: rtl/wb_addr_calc.sv
// wb_addr_calc: byte address of element (row, col) in a row-major double matrix
module wb_addr_calc import systolic_pkg::*; #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [7:0]            k3,
  input  logic [8:0]            row,
  input  logic [8:0]            col,
  output logic [ADDR_WIDTH-1:0] addr
);
  localparam int IW = ADDR_WIDTH + 16;
  logic [IW-1:0] elem;
  assign elem = IW'(row) * IW'(k3) + IW'(col);
  assign addr = ADDR_WIDTH'((elem << WORD_SHIFT) + IW'(base & ~ADDR_WIDTH'(BYTES_PER_WORD - 1)));
endmodule

// File: rtl/c_tile_writeback.sv
// c_tile_writeback: drains one MxM result tile and writes the clipped region to memory
module c_tile_writeback import systolic_pkg::*; #(
  parameter int M = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      C_base_addr,
  input  logic [7:0]                 K3,
  input  logic [7:0]                 tile_row,
  input  logic [7:0]                 tile_col,
  input  logic [$clog2(M+1)-1:0]     rows_valid,
  input  logic [$clog2(M+1)-1:0]     cols_valid,
  input  logic                       row_valid,
  output logic                       row_ready,
  input  logic [M*DATA_WIDTH-1:0]    row_data,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic                       busy,
  output logic                       done
);
  localparam int RW = $clog2(M + 1);
  wb_state_t state, state_n;
  logic [RW-1:0] r, r_n, c, c_n, rows_q, cols_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_n;
  logic [7:0] k3_q, trow_q, tcol_q;
  logic [M*DATA_WIDTH-1:0] buf_q, buf_n;
  logic go, hs, take, last_r, last_c;
  assign go = state == IDLE && start;
  assign hs = row_ready && row_valid;
  assign take = r < rows_q && cols_q != '0;
  assign last_r = r == RW'(M - 1);
  assign last_c = c + RW'(1) == cols_q;
  assign buf_n = hs && take ? row_data : buf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      r <= '0;
      c <= '0;
    end else begin
      state <= state_n;
      r <= r_n;
      c <= c_n;
    end
  end
  always_comb begin
    case (state)
      IDLE:     state_n = start ? WAIT_ROW : IDLE;
      WAIT_ROW: state_n = !hs ? WAIT_ROW : take ? WRITE : last_r ? DONE : WAIT_ROW;
      WRITE:    state_n = !last_c ? WRITE : last_r ? DONE : WAIT_ROW;
      default:  state_n = IDLE;
    endcase
    r_n = go ? '0 : ((hs && !take) || (state == WRITE && last_c)) && !last_r ? r + RW'(1) : r;
    c_n = state == WRITE && !last_c ? c + RW'(1) : '0;
  end
  wb_addr_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .base(base_q),
    .k3(k3_q),
    .row(9'(trow_q) + 9'(r_n)),
    .col(9'(tcol_q) + 9'(c_n)),
    .addr(addr_n)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      row_ready <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      row_ready <= state_n == WAIT_ROW;
      mem_we <= state_n == WRITE;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      if (state_n == WRITE) begin
        mem_addr <= addr_n;
        mem_wdata <= buf_n[c_n*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  always_ff @(posedge clk) begin
    buf_q <= buf_n;
    if (go) begin
      base_q <= C_base_addr;
      k3_q <= K3;
      trow_q <= tile_row;
      tcol_q <= tile_col;
      rows_q <= rows_valid;
      cols_q <= cols_valid;
    end
  end
endmodule
